// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch queue feeding the dispatcher.
//
// Owns the fetch PC, issues one word request per cycle to a fixed one-cycle
// latency instruction memory, and buffers the returned words (each paired
// with its PC+4) in a circular FIFO of DEPTH entries. The head entry is
// presented combinationally to the dispatcher. A jump/branch strobe flushes
// all buffered and in-flight work and redirects the fetch PC.
//
// Optional build macro: IFQ_STATS_EN adds saturating statistics counters
// (stat_fetched, stat_flushes, stat_full_cycles). Functional behaviour is
// identical with or without it.
//
// Handshake summary (all single-cycle, no backpressure on the memory side):
//   - imem_req=1 in cycle N means imem_addr is a valid request in cycle N;
//     imem_rdata carries the answer during cycle N+1 and is captured at the
//     end of N+1 unless a flush happens in N+1.
//   - dispatch_ren=1 pops the head at the end of the cycle only when the
//     queue is non-empty and no flush is present; on an empty queue it is a
//     no-op.
//   - dispatch_jump_branch=1 is a one-cycle strobe that wins over capture,
//     pop and request in the same cycle.
//
// No state machine beyond the one-bit in-flight tracker: the block is a
// pointer/counter FIFO plus a one-deep request tracker.

module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        dispatch_ren,
  input  logic        dispatch_jump_branch,
  input  logic [31:0] dispatch_jmp_branch_addr,
  output logic [31:0] ifetch_instruction,
  output logic [31:0] ifetch_pc_plus_four,
  output logic        ifetch_empty_flag
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [15:0] stat_flushes,
  output logic [31:0] stat_full_cycles
`endif
);

  // Pointer width and count width (count must be able to hold DEPTH itself).
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [CW-1:0] CNT_ONE   = 1;
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  // Occupancy (count + in-flight) needs one more bit than count.
  localparam logic [CW:0]   OCC_LIMIT = (CW+1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q,   req_pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0] count_q,    count_d;

  // Entry storage; validity is defined only by count and the pointers.
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   ppf_mem_q   [DEPTH];

  // ---------------------------------------------------------------------------
  // Per-cycle events
  // ---------------------------------------------------------------------------
  logic          flush;
  logic          capture;
  logic          pop;
  logic          queue_empty;
  logic [CW:0]   occupancy;

  // Decode this cycle's events; flush suppresses everything else.
  always_comb begin
    flush       = dispatch_jump_branch;
    queue_empty = (count_q == '0);
    capture     = inflight_q && !flush;
    pop         = dispatch_ren && !queue_empty && !flush;
    occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  end

  // Request generation: only request when the response is guaranteed a slot,
  // counting the pre-pop occupancy so a full queue can never receive data.
  always_comb begin
    imem_req  = !rst && !flush && (occupancy < OCC_LIMIT);
    imem_addr = fetch_pc_q;
  end

  // Next-state for fetch PC, request tracker, pointers and count.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (flush) begin
      // Redirect: drop all buffered and in-flight work, force word alignment.
      fetch_pc_d = {dispatch_jmp_branch_addr[31:2], 2'b00};
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_pc_d   = fetch_pc_q;
      end
      if (capture) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({capture, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= PC_RESET;
      req_pc_q   <= 32'h0000_0000;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage write: the returned word paired with its PC+4.
  always_ff @(posedge clk) begin
    if (capture) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      ppf_mem_q[wr_ptr_q]   <= req_pc_q + 32'd4;
    end
  end

  // Head presentation; zeros while empty so stale entries never leak out.
  always_comb begin
    ifetch_empty_flag = queue_empty;
    if (queue_empty) begin
      ifetch_instruction  = 32'h0000_0000;
      ifetch_pc_plus_four = 32'h0000_0000;
    end else begin
      ifetch_instruction  = instr_mem_q[rd_ptr_q];
      ifetch_pc_plus_four = ppf_mem_q[rd_ptr_q];
    end
  end

`ifdef IFQ_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics (saturating at all-ones)
  // ---------------------------------------------------------------------------
  logic [31:0] stat_fetched_q,     stat_fetched_d;
  logic [15:0] stat_flushes_q,     stat_flushes_d;
  logic [31:0] stat_full_cycles_q, stat_full_cycles_d;

  // Saturating increments for each statistic.
  always_comb begin
    stat_fetched_d     = stat_fetched_q;
    stat_flushes_d     = stat_flushes_q;
    stat_full_cycles_d = stat_full_cycles_q;
    if (capture && (stat_fetched_q != '1)) begin
      stat_fetched_d = stat_fetched_q + 32'd1;
    end
    if (flush && (stat_flushes_q != '1)) begin
      stat_flushes_d = stat_flushes_q + 16'd1;
    end
    if ((count_q == CNT_FULL) && (stat_full_cycles_q != '1)) begin
      stat_full_cycles_d = stat_full_cycles_q + 32'd1;
    end
  end

  // Statistics registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetched_q     <= '0;
      stat_flushes_q     <= '0;
      stat_full_cycles_q <= '0;
    end else begin
      stat_fetched_q     <= stat_fetched_d;
      stat_flushes_q     <= stat_flushes_d;
      stat_full_cycles_q <= stat_full_cycles_d;
    end
  end

  // Expose statistics.
  always_comb begin
    stat_fetched     = stat_fetched_q;
    stat_flushes     = stat_flushes_q;
    stat_full_cycles = stat_full_cycles_q;
  end
`endif

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch queue that sits directly upstream of the dispatcher.
- Owns the fetch PC and issues word requests to a fixed-latency instruction memory.
- Buffers the returned instructions, each paired with its PC+4, in a circular FIFO.
- Presents the head entry to the dispatcher and pops it on dispatch_ren. A jump or taken branch flushes the queue and redirects the fetch PC.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PC_RESET, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  32  word-aligned fetch address; valid while imem_req=1.
- imem_rdata  input  32  instruction word; valid exactly 1 cycle after the cycle with imem_req=1.
- dispatch_ren  input  1  dispatcher read enable; pops the head when the queue is non-empty.
- dispatch_jump_branch  input  1  flush/redirect strobe, single-cycle.
- dispatch_jmp_branch_addr  input  32  redirect target; sampled when dispatch_jump_branch=1.
- ifetch_instruction  output  32  head instruction; 32'h0 when the queue is empty.
- ifetch_pc_plus_four  output  32  head PC+4; 32'h0 when the queue is empty.
- ifetch_empty_flag  output  1  1 when the queue holds no entries.

Behaviour:
- Reset (asynchronous, active-high):
  - fetch_pc=PC_RESET.
  - rd_ptr=wr_ptr=0, count=0.
  - inflight=0, req_pc=0.
  - imem_req=0, ifetch_empty_flag=1, ifetch_instruction=0, ifetch_pc_plus_four=0.
- Storage:
  - DEPTH entries, each {pc_plus_four[31:0], instr[31:0]}.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Request generation (combinational):
  - imem_req = !dispatch_jump_branch && (count + inflight) < DEPTH.
  - imem_addr = fetch_pc.
  - Consequence: no response can ever arrive to a full queue. The bound uses count before this cycle's pop (conservative by design).
- On each cycle with imem_req=1:
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
  - req_pc <= fetch_pc.
  - inflight <= 1.
- On cycles with imem_req=0: inflight <= 0.
- Response capture:
  - Condition: inflight=1 and dispatch_jump_branch=0.
  - Write {req_pc+4, imem_rdata} at wr_ptr; wr_ptr++.
- Pop:
  - Condition: dispatch_ren=1, count!=0 and dispatch_jump_branch=0.
  - rd_ptr++.
  - dispatch_ren with an empty queue is ignored; no underflow.
- count update:
  - +1 on write only, -1 on pop only.
  - Unchanged when a write and a pop occur in the same cycle.
- Head outputs:
  - Combinational from entry[rd_ptr], forced to 0 when count==0.
  - ifetch_empty_flag = (count==0).
- Latency:
  - Request in cycle N, capture at the end of N+1, visible at head in N+2.
  - After reset release, ifetch_empty_flag falls in the 3rd cycle (cycle 2).
  - Sustained throughput: 1 instr/cycle while the dispatcher pops every cycle.
- Flush (dispatch_jump_branch=1):
  - Same cycle: imem_req=0, no capture (the in-flight response is discarded), no pop.
  - Next edge: rd_ptr=wr_ptr=0, count=0, inflight=0, fetch_pc <= {dispatch_jmp_branch_addr[31:2],2'b00}.
  - First request to the target issues in the cycle after the flush.
  - Flush has priority over every other event.
  - Back-to-back flushes: the last target wins.
- Entries hold stale data after a pop; only count and pointers define validity.
- No state machine beyond inflight: the block is a pointer/counter FIFO with a one-deep request tracker.

Optional Feature:
- Macro: IFQ_STATS_EN.
- Defined: adds output ports stat_fetched (32 bits), stat_flushes (16 bits) and stat_full_cycles (32 bits), all reset to 0.
  - stat_fetched increments on each capture.
  - stat_flushes increments on each dispatch_jump_branch=1 cycle.
  - stat_full_cycles increments each cycle count==DEPTH.
  - All counters saturate at all-ones.
- Undefined: these ports and registers do not exist. Functional behaviour is identical either way.

Test Plan:
- Reset release, imem returns 32'h0000_0013 every cycle, dispatch_ren=0:
  - imem_addr goes 0x0,0x4,0x8,0xC in cycles 0-3.
  - imem_req drops in cycle 4 and stays 0.
  - ifetch_empty_flag=0 from cycle 2.
  - Head ifetch_pc_plus_four=0x4.
- Full queue (DEPTH=4), hold dispatch_ren=1:
  - Pops continue every cycle.
  - Head pc_plus_four advances 0x4,0x8,0xC,0x10,0x14.
  - No bubble after the pipeline refills; count never exceeds 4.
- dispatch_jump_branch=1 with dispatch_jmp_branch_addr=0x0000_0103 while 3 entries are held and one request is in flight:
  - Same cycle: imem_req=0.
  - Next cycle: ifetch_empty_flag=1, imem_addr=0x100.
  - First head pc_plus_four=0x104; the discarded response never appears.
- Write and pop in the same cycle at count=2: count stays 2, and the output order matches the fetch order (no lost or duplicated PC).
- Pointer wrap: fetch 10 instructions through DEPTH=4 with random dispatch_ren; the head pc_plus_four sequence is 0x4..0x28, strictly +4.
- rst asserted mid-stream (count=3, inflight=1): outputs go to reset values immediately, and after release imem_addr restarts at PC_RESET.
